sram_port_arbiter: RTL

- Shares one sram-like memory port (req/addr_ok/data_ok handshake) between the instruction-fetch master and the data (load/store) master.
- Sits between the IF and MEM-side sram-like interfaces and the single bus bridge.
- Tracks outstanding accepted requests in an in-order owner FIFO, so each slave data_ok/rdata is routed back to the master that issued it.

---
 rtl/sram_port_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// Shares one sram-like port (req / addr_ok / data_ok) between the instruction-fetch
// master (inst_*) and the load/store master (data_*).
//
// Arbitration: a request presented to the slave but not yet accepted locks the port
// to its master, so the presented request stays stable and is never preempted.
// When unlocked, data has fixed priority over inst by default. Building with the
// ARB_RR_EN macro defined enables round-robin instead. In that mode, last_grant_q
// records the master of each accept, and on a tie the other master wins.
//
// Accepted requests push their owner ID (0 = inst, 1 = data) into an in-order FIFO
// of OUTSTANDING entries. Each slave data_ok pops the head, and the response is routed
// combinationally to that owner. A data_ok that arrives while the FIFO is empty is
// ignored.
//
// Ports:
//   clk_i, resetn_i          clock, async active-low reset
//   inst_* / data_*          master request side (req, wr, size, addr, wstrb, wdata in;
//                            addr_ok, data_ok, rdata out)
//   sl_*                     shared slave side (req, wr, size, addr, wstrb, wdata out;
//                            addr_ok, data_ok, rdata in)
module sram_port_arbiter #(
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned OWN_W       = 2
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        inst_req_i,
  input  logic        inst_wr_i,
  input  logic [1:0]  inst_size_i,
  input  logic [31:0] inst_addr_i,
  input  logic [3:0]  inst_wstrb_i,
  input  logic [31:0] inst_wdata_i,
  output logic        inst_addr_ok_o,
  output logic        inst_data_ok_o,
  output logic [31:0] inst_rdata_o,
  input  logic        data_req_i,
  input  logic        data_wr_i,
  input  logic [1:0]  data_size_i,
  input  logic [31:0] data_addr_i,
  input  logic [3:0]  data_wstrb_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_addr_ok_o,
  output logic        data_data_ok_o,
  output logic [31:0] data_rdata_o,
  output logic        sl_req_o,
  output logic        sl_wr_o,
  output logic [1:0]  sl_size_o,
  output logic [31:0] sl_addr_o,
  output logic [3:0]  sl_wstrb_o,
  output logic [31:0] sl_wdata_o,
  input  logic        sl_addr_ok_i,
  input  logic        sl_data_ok_i,
  input  logic [31:0] sl_rdata_i
);

  localparam logic [OWN_W:0]   MaxCnt  = (OWN_W+1)'(OUTSTANDING);
  localparam logic [OWN_W:0]   CntOne  = (OWN_W+1)'(1);
  localparam logic [OWN_W-1:0] LastPtr = OWN_W'(OUTSTANDING - 1);
  localparam logic [OWN_W-1:0] PtrOne  = OWN_W'(1);

  typedef enum logic [1:0] {StUnlocked, StLockedInst, StLockedData} lock_e;

  lock_e state_q, state_d;

  logic                    owner_vld;
  logic                    owner_data;   // 1 = data master owns the port
  logic                    sel_data;
  logic                    owner_req;
  logic                    full;
  logic                    push;
  logic                    pop;
  logic                    head_data;

  logic [OWN_W:0]          cnt_q, cnt_d;
  logic [OWN_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [OWN_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [(1<<OWN_W)-1:0]   fifo_q, fifo_d;

`ifdef ARB_RR_EN
  logic last_grant_q;  // 0 = inst, 1 = data
`endif

  // Lock state register
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= StUnlocked;
    end else begin
      state_q <= state_d;
    end
  end

  // Lock next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StUnlocked: begin
        if (sl_req_o && !sl_addr_ok_i) begin
          state_d = owner_data ? StLockedData : StLockedInst;
        end
      end
      StLockedInst, StLockedData: begin
        if (push) state_d = StUnlocked;
      end
      default: state_d = StUnlocked;
    endcase
  end

  // Owner selection and request forwarding
  always_comb begin
    owner_vld  = 1'b0;
    owner_data = 1'b0;
    case (state_q)
      StLockedInst: begin
        owner_vld  = 1'b1;
        owner_data = 1'b0;
      end
      StLockedData: begin
        owner_vld  = 1'b1;
        owner_data = 1'b1;
      end
      default: begin
`ifdef ARB_RR_EN
        if (data_req_i && inst_req_i) begin
          owner_vld  = 1'b1;
          owner_data = ~last_grant_q;
        end else if (data_req_i) begin
          owner_vld  = 1'b1;
          owner_data = 1'b1;
        end else if (inst_req_i) begin
          owner_vld  = 1'b1;
          owner_data = 1'b0;
        end
`else
        if (data_req_i) begin
          owner_vld  = 1'b1;
          owner_data = 1'b1;
        end else if (inst_req_i) begin
          owner_vld  = 1'b1;
          owner_data = 1'b0;
        end
`endif
      end
    endcase
  end

  assign sel_data  = owner_vld & owner_data;
  assign owner_req = owner_vld & (owner_data ? data_req_i : inst_req_i);
  assign full      = (cnt_q == MaxCnt);

  // Gated by reset so nothing is issued or acknowledged while resetn_i is low
  assign sl_req_o  = resetn_i & owner_req & ~full;
  assign push      = sl_req_o & sl_addr_ok_i;
  assign pop       = resetn_i & sl_data_ok_i & (cnt_q != '0);
  assign head_data = fifo_q[rd_ptr_q];

  assign sl_wr_o    = sel_data ? data_wr_i    : inst_wr_i;
  assign sl_size_o  = sel_data ? data_size_i  : inst_size_i;
  assign sl_addr_o  = sel_data ? data_addr_i  : inst_addr_i;
  assign sl_wstrb_o = sel_data ? data_wstrb_i : inst_wstrb_i;
  assign sl_wdata_o = sel_data ? data_wdata_i : inst_wdata_i;

  assign inst_addr_ok_o = push & ~owner_data;
  assign data_addr_ok_o = push & owner_data;
  assign inst_data_ok_o = pop & ~head_data;
  assign data_data_ok_o = pop & head_data;
  assign inst_rdata_o   = sl_rdata_i;
  assign data_rdata_o   = sl_rdata_i;

  // Owner FIFO next state; pointers wrap at OUTSTANDING, not at 2^OWN_W
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = owner_data;
      wr_ptr_d         = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrOne;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntOne;
      2'b01:   cnt_d = cnt_q - CntOne;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      last_grant_q <= 1'b0;
    end else if (push) begin
      last_grant_q <= owner_data;
    end
  end
`endif

endmodule
